desplaza_iterativo: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the microprocessor datapath and DMA address/data formatting. Replaces the single-cycle left/right-only logical shifter. Adds the following:
- arithmetic right shift, rotate left and rotate right;
- generic width;
- start/busy/done handshake.

Shifting is done over log2(WIDTH) cycles, one shift-amount bit per cycle, so one small stage replaces a full barrel shifter.

---
 rtl/desplaza_pkg.sv | 16 +
 rtl/desplaza_etapa.sv | 32 +++
 rtl/desplaza_iterativo.sv | 99 +++++++++
 tb/tb_desplaza_iterativo.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/desplaza_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation codes and FSM states.
package desplaza_pkg;

    localparam logic [2:0] MODO_SLL = 3'd0;
    localparam logic [2:0] MODO_SRL = 3'd1;
    localparam logic [2:0] MODO_SRA = 3'd2;
    localparam logic [2:0] MODO_ROL = 3'd3;
    localparam logic [2:0] MODO_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } estado_t;

endpackage

// File: rtl/desplaza_etapa.sv
// One shift/rotate stage: moves the value by 2^k positions in the selected mode.
module desplaza_etapa
    import desplaza_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] valor_i,
    input  logic [SHW-1:0]   etapa_i,
    input  logic [2:0]       modo_i,
    output logic [WIDTH-1:0] valor_o
);

    localparam logic [SHW:0] ANCHO = (SHW+1)'(WIDTH);

    // The largest stage moves WIDTH/2 positions, so one extra bit holds every amount.
    logic [SHW:0] amt;
    assign amt = (SHW+1)'(1) << etapa_i;

    always_comb begin
        valor_o = valor_i;
        case (modo_i)
            MODO_SLL: valor_o = valor_i << amt;
            MODO_SRL: valor_o = valor_i >> amt;
            MODO_SRA: valor_o = $signed(valor_i) >>> amt;
            MODO_ROL: valor_o = (valor_i << amt) | (valor_i >> (ANCHO - amt));
            MODO_ROR: valor_o = (valor_i >> amt) | (valor_i << (ANCHO - amt));
            default:  valor_o = valor_i;
        endcase
    end

endmodule

// File: rtl/desplaza_iterativo.sv
// Multi-cycle shift/rotate unit: one shift-amount bit per cycle through a single stage,
// with a start/busy/done handshake and an illegal-mode error flag.
module desplaza_iterativo
    import desplaza_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dato_in,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       modo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dato_out,
    output logic             err
);

    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

    estado_t          estado_q;
    logic [SHW-1:0]   k_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] etapa_out;
    logic [SHW-1:0]   shamt_q;
    logic [2:0]       modo_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dato_out_q;
    logic             err_q;

    desplaza_etapa #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_etapa (
        .valor_i (acc_q),
        .etapa_i (k_q),
        .modo_i  (modo_q),
        .valor_o (etapa_out)
    );

    // Stage k only applies when the matching shift-amount bit is set.
    always_comb begin
        acc_d = shamt_q[k_q] ? etapa_out : acc_q;
    end

    // Outputs are registered images of the state: busy follows SHIFT and done/result
    // follow DONE one clock later, so start-to-done is always SHW+1 edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= ST_IDLE;
            k_q        <= '0;
            acc_q      <= '0;
            shamt_q    <= '0;
            modo_q     <= MODO_SLL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dato_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q <= (estado_q == ST_SHIFT);
            done_q <= (estado_q == ST_DONE);
            if (estado_q == ST_DONE) begin
                dato_out_q <= acc_q;
                err_q      <= (modo_q > MODO_ROR);
            end
            case (estado_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        acc_q    <= dato_in;
                        shamt_q  <= shamt;
                        modo_q   <= modo;
                        k_q      <= '0;
                        estado_q <= ST_SHIFT;
                    end else begin
                        estado_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        estado_q <= ST_DONE;
                    end
                end
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign dato_out = dato_out_q;
    assign err      = err_q;

endmodule

// File: tb/tb_desplaza_iterativo.sv
// Directed bench for desplaza_iterativo (WIDTH=32): results, latency, handshake and reset abort.
module tb_desplaza_iterativo;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dato_in;
    logic [4:0]   shamt;
    logic [2:0]   modo;
    logic         busy;
    logic         done;
    logic [W-1:0] dato_out;
    logic         err;

    int tests_run = 0;
    int tests_failed = 0;

    desplaza_iterativo #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dato_in  (dato_in),
        .shamt    (shamt),
        .modo     (modo),
        .busy     (busy),
        .done     (done),
        .dato_out (dato_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issues one operation from IDLE and checks latency, busy length, result and err.
    task automatic run_op(input string tag, input logic [2:0] m, input logic [W-1:0] d,
                          input logic [4:0] s, input logic [W-1:0] exp_v, input logic exp_e,
                          input bit glitch);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start   = 1'b1;
        dato_in = d;
        shamt   = s;
        modo    = m;
        @(posedge clk);
        #1;
        start   = 1'b0;
        dato_in = ~d;
        shamt   = ~s;
        modo    = 3'd0;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (glitch && cyc == 2) begin
                start   = 1'b1;
                dato_in = 32'hFFFF_FFFF;
                shamt   = 5'd1;
                modo    = 3'd3;
            end
            if (glitch && cyc == 3) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc;
                break;
            end
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        chk({tag, " latency"}, W'(lat), W'(6));
        chk({tag, " busy_cycles"}, W'(busy_cnt), W'(5));
        chk({tag, " dato_out"}, dato_out, exp_v);
        chk({tag, " err"}, W'(err), W'(exp_e));
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        int lat;
        int done_cnt;
        reset   = 1'b1;
        start   = 1'b0;
        dato_in = '0;
        shamt   = '0;
        modo    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dato_out", dato_out, 32'h0);
        chk("reset busy", W'(busy), W'(0));
        chk("reset done", W'(done), W'(0));
        chk("reset err", W'(err), W'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op("sll_1_31",   3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
        run_op("sra_8_4",    3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
        run_op("srl_8_4",    3'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0);
        run_op("ror_f1_4",   3'd4, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 1'b0);
        run_op("rol_81_1",   3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1'b0);
        run_op("srl_zero",   3'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0);
        run_op("illegal_7",  3'd7, 32'h1234_5678, 5'd3,  32'h1234_5678, 1'b1, 1'b0);
        run_op("sll_clr",    3'd0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0);
        run_op("rol_8",      3'd3, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1'b0);
        run_op("sra_pos",    3'd2, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1'b0, 1'b0);
        run_op("ror_31",     3'd4, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0, 1'b0);
        run_op("sll_16",     3'd0, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b0, 1'b0);
        run_op("rol_zero",   3'd3, 32'hCAFE_F00D, 5'd0,  32'hCAFE_F00D, 1'b0, 1'b0);
        run_op("start_in_shift", 3'd1, 32'hF000_0000, 5'd8, 32'h00F0_0000, 1'b0, 1'b1);

        // Back-to-back: second start presented so it is sampled in the DONE cycle.
        @(negedge clk);
        start = 1'b1; dato_in = 32'h0000_0003; shamt = 5'd2; modo = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; dato_in = 32'h0000_0003; shamt = 5'd1; modo = 3'd4;
        @(posedge clk);
        #1;
        start = 1'b0; dato_in = '0; shamt = '0; modo = '0;
        chk("b2b first done", W'(done), W'(1));
        chk("b2b first dato_out", dato_out, 32'h0000_000C);
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        chk("b2b second latency", W'(lat), W'(6));
        chk("b2b second dato_out", dato_out, 32'h8000_0001);

        run_op("illegal_6", 3'd6, 32'hA5A5_A5A5, 5'd7, 32'hA5A5_A5A5, 1'b1, 1'b0);

        // Reset in the middle of SHIFT clears outputs immediately, off the clock edge.
        @(negedge clk);
        start = 1'b1; dato_in = 32'h0000_00FF; shamt = 5'd3; modo = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort dato_out", dato_out, 32'h0);
        chk("abort err", W'(err), W'(0));
        chk("abort busy", W'(busy), W'(0));
        chk("abort done", W'(done), W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("abort no_done", W'(done_cnt), W'(0));

        run_op("after_abort", 3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
